// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle MULT/DIV sequencer.
package cpu_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_MULT_STEP = 3'd2,
        ST_DIV_STEP  = 3'd3,
        ST_FIX_SIGN  = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    // Operation select carried on the op input
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // R-type funct codes decoded by the main control unit
    localparam logic [5:0] MULT_FUNCT = 6'b011000;
    localparam logic [5:0] DIV_FUNCT  = 6'b011010;

    // Iteration count and matching counter width
    localparam int ITERATIONS = 32;
    localparam int CNT_W      = $clog2(ITERATIONS);

endpackage

// File: rtl/mult_div_ctrl_md_step.sv
// Combinational single iteration: one radix-2 Booth step or one restoring divide step.
module md_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_op,
    input  logic [WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_qm1,
    input  logic [WIDTH:0]   i_opnd,
    output logic [WIDTH:0]   o_acc,
    output logic [WIDTH-1:0] o_q,
    output logic             o_qm1
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;

    // Next acc/q/q_-1 (Booth) or rem/quo (restoring divide) for one iteration
    always_comb begin
        w_sum    = '0;
        w_rem_sh = '0;
        w_diff   = '0;
        o_acc    = i_acc;
        o_q      = i_q;
        o_qm1    = i_qm1;
        if (i_op == OP_MULT) begin
            case ({i_q[0], i_qm1})
                2'b01:   w_sum = i_acc + i_opnd;
                2'b10:   w_sum = i_acc - i_opnd;
                default: w_sum = i_acc;
            endcase
            // arithmetic right shift of {acc, q, q_-1}
            o_acc = {w_sum[WIDTH], w_sum[WIDTH:1]};
            o_q   = {w_sum[0], i_q[WIDTH-1:1]};
            o_qm1 = i_q[0];
        end else begin
            // remainder stays below the divisor magnitude, so the shifted
            // value and the trial difference both fit in WIDTH+1 bits
            w_rem_sh = {i_acc[WIDTH-1:0], i_q[WIDTH-1]};
            w_diff   = w_rem_sh - i_opnd;
            if (w_diff[WIDTH] == 1'b0) begin
                o_acc = w_diff;
                o_q   = {i_q[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = w_rem_sh;
                o_q   = {i_q[WIDTH-2:0], 1'b0};
            end
            o_qm1 = 1'b0;
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// Multicycle signed MULT/DIV sequencer owning the HI/LO register pair.
module mult_div_ctrl
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             hilo_write,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             r_state;
    state_t             w_next;
    logic               r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH:0]     r_acc;
    logic [WIDTH-1:0]   r_q;
    logic               r_qm1;
    logic [WIDTH:0]     r_opnd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_busy;
    logic               r_done;
    logic               r_dz;
    logic               r_hw;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_dz_nxt;
    logic               w_hw_nxt;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_acc_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               w_qm1_nxt;

    assign busy       = r_busy;
    assign done       = r_done;
    assign div_zero   = r_dz;
    assign hilo_write = r_hw;
    assign hi         = r_hi;
    assign lo         = r_lo;

    // Operand magnitudes; the most negative value maps to its unsigned magnitude
    assign w_a_mag = r_a[WIDTH-1] ? (-r_a) : r_a;
    assign w_b_mag = r_b[WIDTH-1] ? (-r_b) : r_b;

    md_step #(.WIDTH(WIDTH)) u_step (
        .i_op   (r_op),
        .i_acc  (r_acc),
        .i_q    (r_q),
        .i_qm1  (r_qm1),
        .i_opnd (r_opnd),
        .o_acc  (w_acc_nxt),
        .o_q    (w_q_nxt),
        .o_qm1  (w_qm1_nxt)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and next values of the registered status outputs
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_LOAD;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (r_op == OP_DIV) begin
                    if (r_b == '0) begin
                        w_next = ST_FINISH;
                    end else begin
                        w_next = ST_DIV_STEP;
                    end
                end else begin
                    w_next = ST_MULT_STEP;
                end
            end
            ST_MULT_STEP, ST_DIV_STEP: begin
                if (r_cnt == '0) begin
                    w_next = ST_FIX_SIGN;
                end else begin
                    w_next = r_state;
                end
            end
            ST_FIX_SIGN: w_next = ST_FINISH;
            ST_FINISH:   w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
        w_busy_nxt = (w_next != ST_IDLE);
        w_done_nxt = (w_next == ST_FINISH);
        // only LOAD jumps straight to FINISH, and only for a zero divisor
        w_dz_nxt   = (r_state == ST_LOAD) && (w_next == ST_FINISH);
        w_hw_nxt   = (r_state == ST_FIX_SIGN);
    end

    // Registered status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            r_hw   <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_dz   <= w_dz_nxt;
            r_hw   <= w_hw_nxt;
        end
    end

    // Operand capture, iteration datapath, counter, sign fix-up and HI/LO
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_op    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_opnd  <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op <= op;
                        r_a  <= a_in;
                        r_b  <= b_in;
                    end
                end
                ST_LOAD: begin
                    r_acc <= '0;
                    r_qm1 <= 1'b0;
                    r_cnt <= CNT_W'(ITERATIONS - 1);
                    if (r_op == OP_MULT) begin
                        r_q    <= r_b;
                        r_opnd <= {r_a[WIDTH-1], r_a};
                    end else begin
                        r_q     <= w_a_mag;
                        r_opnd  <= {1'b0, w_b_mag};
                        r_neg_q <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
                        r_neg_r <= r_a[WIDTH-1];
                    end
                end
                ST_MULT_STEP, ST_DIV_STEP: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_qm1 <= w_qm1_nxt;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_FIX_SIGN: begin
                    // HI/LO load on the edge entering FINISH
                    if (r_op == OP_MULT) begin
                        r_hi <= r_acc[WIDTH-1:0];
                        r_lo <= r_q;
                    end else begin
                        r_lo <= r_neg_q ? (-r_q) : r_q;
                        r_hi <= r_neg_r ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed scoreboard bench for mult_div_ctrl.
module tb_mult_div_ctrl;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic        hw;
    } exp_t;

    logic        clock;
    logic        rst_n;
    logic        start_s;
    logic        op_s;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        hilo_write;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t        sb[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          tests;
    int          fails;

    mult_div_ctrl #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (rst_n),
        .start      (start_s),
        .op         (op_s),
        .a_in       (a_s),
        .b_in       (b_s),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hilo_write (hilo_write),
        .hi         (hi),
        .lo         (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result built from language arithmetic, pushed before start
    task automatic push_expected(input logic o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sbv;
        logic [63:0] p;
        logic [63:0] qv;
        logic [63:0] rv;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (o == 1'b0) begin
            p    = 64'(sa * sbv);
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.dz = 1'b0;
            e.hw = 1'b1;
        end else if (b == 32'd0) begin
            e.hi = m_hi;
            e.lo = m_lo;
            e.dz = 1'b1;
            e.hw = 1'b0;
        end else begin
            qv   = 64'(sa / sbv);
            rv   = 64'(sa % sbv);
            e.hi = rv[31:0];
            e.lo = qv[31:0];
            e.dz = 1'b0;
            e.hw = 1'b1;
        end
        sb.push_back(e);
    endtask

    // Issue one request, wait for done (bounded), compare against the scoreboard
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          input int exp_edge, input int pulse_k, input bit pulse_fin,
                          input string tag);
        exp_t e;
        int   k;
        bit   seen;
        push_expected(o, a, b);
        @(negedge clock);
        op_s    = o;
        a_s     = a;
        b_s     = b;
        start_s = 1'b1;
        @(posedge clock);
        #1;
        start_s = 1'b0;
        check({tag, " busy_after_start"}, 64'(busy), 64'd1);
        seen = 1'b0;
        k    = 1;
        while (k <= 60 && !seen) begin
            @(posedge clock);
            #1;
            start_s = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (k == 17) begin
                    check({tag, " hilo_stable"}, {hi, lo}, {m_hi, m_lo});
                end
                if (k == pulse_k) begin
                    start_s = 1'b1;
                    op_s    = ~o;
                    a_s     = 32'h0000_1234;
                    b_s     = 32'h0000_0000;
                end
                k++;
            end
        end
        check({tag, " done_edge"}, 64'(k), 64'(exp_edge));
        if (seen) begin
            e = sb.pop_front();
            check({tag, " hi"}, 64'(hi), 64'(e.hi));
            check({tag, " lo"}, 64'(lo), 64'(e.lo));
            check({tag, " div_zero"}, 64'(div_zero), 64'(e.dz));
            check({tag, " hilo_write"}, 64'(hilo_write), 64'(e.hw));
            check({tag, " busy_in_finish"}, 64'(busy), 64'd1);
            if (e.hw) begin
                m_hi = e.hi;
                m_lo = e.lo;
            end
        end
        if (pulse_fin) begin
            start_s = 1'b1;
            op_s    = 1'b0;
            a_s     = 32'h0000_0009;
            b_s     = 32'h0000_0009;
        end
        @(posedge clock);
        #1;
        start_s = 1'b0;
        check({tag, " done_cleared"}, {62'd0, done, div_zero}, 64'd0);
        check({tag, " idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int ndone;
        tests   = 0;
        fails   = 0;
        m_hi    = 32'd0;
        m_lo    = 32'd0;
        rst_n   = 1'b0;
        start_s = 1'b0;
        op_s    = 1'b0;
        a_s     = 32'd0;
        b_s     = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_flags", {60'd0, busy, done, div_zero, hilo_write}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clock);
        rst_n = 1'b1;

        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 34, 0, 1'b0, "mult_7x-3");
        check("mult_7x-3_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 34, 0, 1'b0, "mult_min_sq");
        check("mult_min_sq_const", {hi, lo}, 64'h4000_0000_0000_0000);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 34, 0, 1'b0, "div_-7/2");
        check("div_-7/2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 0, 1'b0, "div_overflow");
        check("div_overflow_const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(1'b0, 32'h1234_5678, 32'h8765_4321, 34, 0, 1'b0, "mult_mixed");
        run_op(1'b1, 32'd1000, 32'hFFFF_FFF9, 34, 0, 1'b0, "div_pos_neg");
        run_op(1'b1, 32'h0000_0451, 32'h0000_0020, 34, 0, 1'b0, "div_prep");
        check("div_prep_const", {hi, lo}, 64'h0000_0011_0000_0022);
        run_op(1'b1, 32'd5, 32'd0, 1, 0, 1'b0, "div_zero");
        check("div_zero_hilo_kept", {hi, lo}, 64'h0000_0011_0000_0022);

        // start mid-run and in FINISH are both ignored
        run_op(1'b0, 32'd11, 32'd13, 34, 10, 1'b1, "ignored_start");
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done || busy) ndone++;
        end
        check("no_extra_done", 64'(ndone), 64'd0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd6, 34, 0, 1'b0, "fresh_start");

        // asynchronous abort during a DIV
        @(negedge clock);
        op_s    = 1'b1;
        a_s     = 32'd100;
        b_s     = 32'd7;
        start_s = 1'b1;
        @(posedge clock);
        #1;
        start_s = 1'b0;
        repeat (20) @(posedge clock);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clock);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        run_op(1'b0, 32'd3, 32'd4, 34, 0, 1'b0, "mult_3x4");
        check("mult_3x4_const", {hi, lo}, 64'd12);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_div_ctrl.md
# mult_div_ctrl

Multicycle sequencer for the MULT and DIV R-type instructions (funct 011000 / 011010). The main control unit pulses `start` with operands from the A/B registers and waits on `busy`/`done`. The block then runs a 32-iteration signed Booth multiply or signed restoring divide, and loads the HI/LO pair. It owns HI/LO so that MFHI/MFLO read its outputs directly, and it reports division by zero to the exception path.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI/LO are each `WIDTH` bits.

Ports:
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `op`  in  1  0 = MULT, 1 = DIV; sampled with `start`
- `a_in`  in  WIDTH  rs operand (multiplicand / dividend)
- `b_in`  in  WIDTH  rt operand (multiplier / divisor)
- `busy`  out  1  high from the cycle after `start` is accepted until `done`, inclusive
- `done`  out  1  one-cycle completion pulse
- `div_zero`  out  1  one-cycle pulse coincident with `done` when a DIV has divisor 0
- `hilo_write`  out  1  pulse coincident with `done` when HI/LO were updated
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
States: IDLE, LOAD, MULT_STEP, DIV_STEP, FIX_SIGN, FINISH.
- **IDLE:** when `start` is 1, capture `a_in`, `b_in` and `op`, then go to LOAD. Otherwise hold.
- **LOAD:**
  - MULT: initialise {acc = 0, q = b, q_-1 = 0}; set the iteration counter to 31; go to MULT_STEP.
  - DIV with `b` = 0: go to FINISH with the zero flag set.
  - DIV otherwise: latch the operand signs, replace the operands by their magnitudes, clear the remainder, counter = 31; go to DIV_STEP.
- **MULT_STEP:** one radix-2 Booth step per cycle.
  - Add, subtract or skip based on {q[0], q_-1}.
  - Arithmetic right shift of {acc, q, q_-1}.
  - At counter = 0, go to FIX_SIGN; otherwise decrement.
- **DIV_STEP:** one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial subtract the divisor magnitude; if the result is ≥ 0, keep it and set quo[0] = 1.
  - At counter = 0, go to FIX_SIGN; otherwise decrement.
- **FIX_SIGN:**
  - MULT: pass through unchanged.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Go to FINISH.
- **FINISH:**
  - Normal completion: `done` = 1 and `hilo_write` = 1.
    - MULT: {hi, lo} = 64-bit product.
    - DIV: lo = quotient, hi = remainder.
  - Divide by zero: `done` = 1, `div_zero` = 1, `hilo_write` = 0, and HI/LO are unchanged.
  - Next state is IDLE.

Arithmetic rules:
- All arithmetic is two's-complement, WIDTH+1 bits internally.
- The 64-bit product is exact.
- Overflow case 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0 (wrap, no flag).

## Timing
- Edge E0 samples `start`. From E0 the FSM passes through LOAD (1 cycle), 32 STEP cycles, FIX_SIGN (1 cycle), then FINISH.
- `done` is high during the cycle after edge E34 (35 cycles after start). A divide by zero ends with `done` after E1.
- `busy` is 1 in every state except IDLE. All outputs are registered.
- `start` while not IDLE is ignored and not queued.
- `start` in the FINISH cycle is also ignored. The next request is accepted once the FSM is back in IDLE.
- HI/LO change only on the edge entering FINISH; they are stable at all other times.
- Reset values: state IDLE, `busy`/`done`/`div_zero`/`hilo_write` = 0, `hi` = `lo` = 0, all internal registers 0.
- Asserting `reset` mid-operation aborts immediately and asynchronously. No `done` is issued, and HI/LO are cleared.

## Structure
- Shared package (`cpu_pkg`):
  - state encoding
  - op encoding (OP_MULT = 0, OP_DIV = 1)
  - MULT_FUNCT / DIV_FUNCT
  - ITERATIONS = 32
- One natural sub-module: `md_step`, a combinational single-iteration unit.
  - Inputs: op, acc/rem, q/quo, q_-1, divisor/multiplicand.
  - Outputs: the next values of those registers.
  - The FSM, counter, sign fix-up and HI/LO registers stay in `mult_div_ctrl`.

## Test plan
- MULT 7 × −3 (a = 7, b = 0xFFFFFFFD) → `done` 35 cycles after start; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; `hilo_write` = 1.
- MULT 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0x00000000.
- DIV −7 / 2 → lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFF (−1). DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIV 5 / 0 with prior HI/LO = 0x11/0x22 → `done` and `div_zero` pulse after E1; `hilo_write` = 0; HI/LO stay 0x11/0x22.
- `start` pulsed at cycle 10 of a running MULT, and in the FINISH cycle → both ignored; exactly one `done`; a fresh `start` in the following IDLE is accepted.
- `reset` low at cycle 20 of a DIV → `busy` = 0 and hi = lo = 0 immediately, no `done`; after release, MULT 3 × 4 gives lo = 12, hi = 0.
